pll_reset_sequencer: RTL
========================

// Module: pll_reset_sequencer
// PURPOSE
//  Control side of the core PLL handshake: drives the PLL reset, watches the asynchronous
//  locked flag, requires lock to be stable, then releases the per-domain core resets in order.
//  On lock loss, timeout or software request it re-runs the sequence.
//  Sits in the refclk domain between the bridge/top level and the 4-output core PLL wrapper.
// PARAMETERS
//  N_DOMAINS          4      number of core reset outputs, released index 0 first
//  RST_PULSE_CYCLES   64     refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_STABLE_CYCLES 4096   consecutive synced-high locked samples required before release
//  LOCK_TIMEOUT       262144 cycles allowed in WAIT_LOCK+STABLE before retry (> LOCK_STABLE_CYCLES)
//  RELEASE_GAP        16     cycles between successive core_rst releases (>=1)
//  SYNC_STAGES        2      flops in the pll_locked synchroniser (>=2)
// PORTS
//  refclk        in   1          reference clock; all logic on rising edge
//  rst           in   1          synchronous, active-high reset
//  pll_locked    in   1          PLL locked, asynchronous to refclk
//  sw_reset_req  in   1          single-cycle request to restart the full sequence
//  pll_rst       out  1          reset to the PLL, registered
//  core_rst      out  N_DOMAINS  per-domain active-high resets, registered
//  ready         out  1          high only in RUN
//  lock_lost     out  1          sticky: lock dropped in RELEASE or RUN; cleared by rst only
//  timeout       out  1          one-cycle pulse when a lock attempt times out
//  retry_count   out  8          count of lock-loss and timeout retries, saturates at 255
// BEHAVIOUR
//  Reset (rst high): state=ASSERT_PLL, counters=0, pll_rst=1, core_rst=all 1, ready=0,
//   lock_lost=0, timeout=0, retry_count=0. The synchroniser chain clears to 0.
//  locked_s = pll_locked after SYNC_STAGES flops. It is the only form of lock used internally.
//  States:
//   ASSERT_PLL: pll_rst=1 and core_rst=all 1. After RST_PULSE_CYCLES cycles -> WAIT_LOCK,
//    so pll_rst is high for exactly RST_PULSE_CYCLES cycles after rst falls. Timeout counter cleared.
//   WAIT_LOCK: pll_rst=0. locked_s=1 -> STABLE with stable counter=1.
//   STABLE: locked_s=1 increments the stable counter. Reaching LOCK_STABLE_CYCLES -> RELEASE.
//    locked_s=0 -> WAIT_LOCK, stable counter cleared. The timeout counter keeps running.
//   Timeout counter runs in WAIT_LOCK and STABLE. Reaching LOCK_TIMEOUT -> ASSERT_PLL,
//    timeout pulses 1 cycle, retry_count++.
//   RELEASE: core_rst[0] falls on the first RELEASE cycle. core_rst[i] falls i*RELEASE_GAP
//    cycles later. One cycle after core_rst[N_DOMAINS-1] falls -> RUN.
//   RUN: ready=1 and all core_rst=0.
//  Lock loss (locked_s=0 in RELEASE or RUN): next cycle state=ASSERT_PLL, all core_rst=1,
//   ready=0, pll_rst=1, lock_lost set, retry_count++.
//  sw_reset_req=1 in any state: -> ASSERT_PLL with counters cleared.
//   It does not change retry_count or lock_lost.
//  Simultaneous events in one cycle:
//   lock loss + sw_reset_req: lock loss accounting applies once; enter ASSERT_PLL.
//   timeout + locked_s reaching the stable count: release wins, no timeout.
//   sw_reset_req during ASSERT_PLL restarts the pulse count.
//  retry_count holds at 255 and never wraps.
//  core_rst bits never go 1->0 outside RELEASE. All outputs are glitch-free registers.
// TESTING (bench params: N_DOMAINS=4, RST_PULSE=4, STABLE=8, TIMEOUT=32, GAP=2, SYNC=2)
//  1. rst 3 cycles then low, pll_locked=0 -> pll_rst high exactly 4 cycles after rst falls;
//     core_rst=4'hF; ready=0.
//  2. pll_locked rises once and stays high -> core_rst[0] falls 10 cycles later (2 sync + 8 stable);
//     core_rst[1..3] fall at +2, +4, +6; ready rises 1 cycle after core_rst[3].
//  3. pll_locked never rises -> timeout pulses 32 cycles after WAIT_LOCK entry;
//     pll_rst re-asserts 4 cycles; retry_count=1; after 300 timeouts retry_count=255.
//  4. pll_locked toggles low for 1 cycle mid-STABLE -> stable count restarts and release is delayed;
//     lock_lost stays 0.
//  5. In RUN, pll_locked drops -> 2 sync cycles + 1 later ready=0, core_rst=4'hF, pll_rst=1;
//     lock_lost=1; retry_count+1. Relock completes the full sequence.
//  6. sw_reset_req in RUN, and also in the same cycle as lock loss -> restart occurs;
//     retry_count increments only in the lock-loss case, and only by 1.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// pll_reset_sequencer : PLL reset / lock qualification / ordered core release
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pll_reset_sequencer #(
    parameter int N_DOMAINS          = 4,
    parameter int RST_PULSE_CYCLES   = 64,
    parameter int LOCK_STABLE_CYCLES = 4096,
    parameter int LOCK_TIMEOUT       = 262144,
    parameter int RELEASE_GAP        = 16,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked_i,
    input  logic                 sw_reset_req_i,
    output logic                 pll_rst_o,
    output logic [N_DOMAINS-1:0] core_rst_o,
    output logic                 ready_o,
    output logic                 lock_lost_o,
    output logic                 timeout_o,
    output logic [7:0]           retry_count_o
);

    localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int RW = $clog2((N_DOMAINS - 1) * RELEASE_GAP + 2);

    typedef enum logic [2:0] {
        S_ASSERT_PLL = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE     = 3'd2,
        S_RELEASE    = 3'd3,
        S_RUN        = 3'd4
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [PW-1:0]          pulse_q;
    logic [SW-1:0]          stab_q;
    logic [TW-1:0]          tmo_q;
    logic [RW-1:0]          rel_q;
    logic                   pll_rst_q;
    logic [N_DOMAINS-1:0]   core_rst_q;
    logic                   ready_q;
    logic                   lock_lost_q;
    logic                   timeout_q;
    logic [7:0]             retry_q;

    logic       locked_s;
    logic       lock_drop;
    logic [7:0] retry_inc;

    assign locked_s  = sync_q[SYNC_STAGES-1];
    assign lock_drop = !locked_s && ((state_q == S_RELEASE) || (state_q == S_RUN));
    assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_ASSERT_PLL;
            pulse_q     <= '0;
            stab_q      <= '0;
            tmo_q       <= '0;
            rel_q       <= '0;
            pll_rst_q   <= 1'b1;
            core_rst_q  <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            timeout_q   <= 1'b0;
            retry_q     <= 8'd0;
        end else begin
            timeout_q <= 1'b0;
            // Lock loss and software restart share the restart path; only loss is accounted.
            if (lock_drop || sw_reset_req_i) begin
                state_q    <= S_ASSERT_PLL;
                pulse_q    <= '0;
                stab_q     <= '0;
                tmo_q      <= '0;
                rel_q      <= '0;
                pll_rst_q  <= 1'b1;
                core_rst_q <= '1;
                ready_q    <= 1'b0;
                if (lock_drop) begin
                    lock_lost_q <= 1'b1;
                    retry_q     <= retry_inc;
                end
            end else begin
                case (state_q)
                    S_ASSERT_PLL: begin
                        tmo_q <= '0;
                        if (int'(pulse_q) == RST_PULSE_CYCLES - 1) begin
                            state_q   <= S_WAIT_LOCK;
                            pulse_q   <= '0;
                            pll_rst_q <= 1'b0;
                        end else begin
                            pulse_q <= pulse_q + PW'(1);
                        end
                    end
                    S_WAIT_LOCK, S_STABLE: begin
                        // A completed stable run beats a timeout landing on the same cycle.
                        if (locked_s && (int'(stab_q) + 1 == LOCK_STABLE_CYCLES)) begin
                            state_q       <= S_RELEASE;
                            stab_q        <= '0;
                            tmo_q         <= '0;
                            rel_q         <= '0;
                            core_rst_q[0] <= 1'b0;
                        end else if (int'(tmo_q) == LOCK_TIMEOUT - 1) begin
                            state_q   <= S_ASSERT_PLL;
                            pulse_q   <= '0;
                            stab_q    <= '0;
                            tmo_q     <= '0;
                            pll_rst_q <= 1'b1;
                            timeout_q <= 1'b1;
                            retry_q   <= retry_inc;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                            if (locked_s) begin
                                state_q <= S_STABLE;
                                stab_q  <= stab_q + SW'(1);
                            end else begin
                                state_q <= S_WAIT_LOCK;
                                stab_q  <= '0;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (int'(rel_q) == (N_DOMAINS - 1) * RELEASE_GAP) begin
                            state_q <= S_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            rel_q <= rel_q + RW'(1);
                            for (int i = 1; i < N_DOMAINS; i++) begin
                                if (int'(rel_q) + 1 == i * RELEASE_GAP) begin
                                    core_rst_q[i] <= 1'b0;
                                end
                            end
                        end
                    end
                    S_RUN: begin
                        ready_q <= 1'b1;
                    end
                    default: begin
                        state_q    <= S_ASSERT_PLL;
                        pulse_q    <= '0;
                        pll_rst_q  <= 1'b1;
                        core_rst_q <= '1;
                        ready_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pll_rst_o     = pll_rst_q;
    assign core_rst_o    = core_rst_q;
    assign ready_o       = ready_q;
    assign lock_lost_o   = lock_lost_q;
    assign timeout_o     = timeout_q;
    assign retry_count_o = retry_q;

endmodule

`default_nettype wire
